// File: rtl/game_pkg.sv
// Shared types and constants for the doodle game frame sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        SCROLL = 3'd2,
        DEAD   = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    localparam logic [7:0] START_KEY = 8'h2C;
    localparam logic [7:0] PAUSE_KEY = 8'h13;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score that drains a pending-point accumulator one point per clock,
// saturating at 9999.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        clear,
    input  logic        load,
    input  logic [9:0]  load_amt,
    input  logic        freeze,
    output logic [15:0] score_bcd,
    output logic        busy
);

    logic [10:0] acc;
    logic [10:0] acc_next;
    logic [10:0] add_amt;
    logic        dec;
    logic        sat;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        bcd_digit_t  d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign sat  = (score_bcd == 16'h9999);
    assign busy = (acc != 11'd0) && !sat;

    // A load landing while points are still draining stacks onto the remainder.
    always_comb begin
        dec      = (acc != 11'd0) && !freeze && !sat;
        add_amt  = (load && !sat) ? {1'b0, load_amt} : 11'd0;
        acc_next = acc - {10'd0, dec} + add_amt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_bcd <= 16'h0000;
            acc       <= 11'd0;
        end else if (clear) begin
            score_bcd <= 16'h0000;
            acc       <= 11'd0;
        end else if (sat) begin
            acc <= 11'd0;
        end else begin
            acc <= acc_next;
            if (dec) begin
                score_bcd <= bcd_inc(score_bcd);
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Frame-level game controller: VSYNC sync, physics strobe, game FSM, scroll and score.
// Optional pause support is enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [9:0] SCROLL_LINE = 10'd160,
    parameter logic [9:0] BOTTOM_Y    = 10'd479,
    parameter logic [9:0] MAX_SCROLL  = 10'd16,
    parameter logic [7:0] OVER_FRAMES = 8'd120
)(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  DoodleY,
    input  logic        rising,
    output logic        frame_tick,
    output logic [9:0]  scroll_amt,
    output logic [2:0]  outstate,
    output logic [15:0] score_bcd,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_PLAY   = PLAY;
    localparam logic [2:0] ST_SCROLL = SCROLL;
    localparam logic [2:0] ST_DEAD   = DEAD;

    logic       fsync_q1, fsync_q2, fsync_q3;
    logic       frame_evt;
    logic [7:0] key_prev;
    logic       start_evt;

    logic [2:0] state, state_next;
    logic [9:0] pending, pending_next;
    logic [7:0] over_cnt, over_cnt_next;
    logic       tick_next;
    logic [9:0] scroll_next;
    logic [9:0] diff, clamp;
    logic       score_clear, score_load, score_freeze;

    assign frame_evt = fsync_q2 && !fsync_q3;
    assign start_evt = (keycode == START_KEY) && (key_prev != START_KEY);
    assign outstate  = state;

    always_comb begin
        diff  = SCROLL_LINE - DoodleY;
        clamp = (diff > MAX_SCROLL) ? MAX_SCROLL : diff;
    end

`ifdef GAME_SEQ_PAUSE_EN
    localparam logic [2:0] ST_PAUSE = PAUSE;
    logic       pause_evt;
    logic [2:0] resume_state, resume_next;
    assign pause_evt    = (keycode == PAUSE_KEY) && (key_prev != PAUSE_KEY);
    assign score_freeze = (state == ST_PAUSE);
`else
    assign score_freeze = 1'b0;
`endif

    // scroll_amt is meaningful only in the cycle frame_tick is high; zero otherwise.
    always_comb begin
        state_next    = state;
        pending_next  = pending;
        over_cnt_next = over_cnt;
        tick_next     = 1'b0;
        scroll_next   = 10'd0;
        score_clear   = 1'b0;
        score_load    = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
        resume_next   = resume_state;
`endif
        case (state)
            ST_IDLE: begin
                if (start_evt) begin
                    state_next   = ST_PLAY;
                    score_clear  = 1'b1;
                    pending_next = 10'd0;
                end
            end
            ST_PLAY: begin
                if (frame_evt) begin
                    tick_next = 1'b1;
                    if (DoodleY >= BOTTOM_Y) begin
                        state_next    = ST_DEAD;
                        over_cnt_next = 8'd0;
                    end else if (rising && (DoodleY < SCROLL_LINE)) begin
                        state_next   = ST_SCROLL;
                        pending_next = clamp;
                    end
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (pause_evt) begin
                    resume_next = ST_PLAY;
                    state_next  = ST_PAUSE;
                end
`endif
            end
            ST_SCROLL: begin
                if (frame_evt) begin
                    tick_next    = 1'b1;
                    scroll_next  = pending;
                    score_load   = 1'b1;
                    pending_next = 10'd0;
                    state_next   = ST_PLAY;
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (pause_evt) begin
                    resume_next = ST_SCROLL;
                    state_next  = ST_PAUSE;
                end
`endif
            end
            ST_DEAD: begin
                if (frame_evt) begin
                    if (over_cnt == OVER_FRAMES - 8'd1) begin
                        state_next    = ST_IDLE;
                        over_cnt_next = 8'd0;
                    end else begin
                        over_cnt_next = over_cnt + 8'd1;
                    end
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (pause_evt) begin
                    state_next = resume_state;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync_q1   <= 1'b0;
            fsync_q2   <= 1'b0;
            fsync_q3   <= 1'b0;
            key_prev   <= 8'h00;
            state      <= ST_IDLE;
            pending    <= 10'd0;
            over_cnt   <= 8'd0;
            frame_tick <= 1'b0;
            scroll_amt <= 10'd0;
        end else begin
            fsync_q1   <= frame_clk;
            fsync_q2   <= fsync_q1;
            fsync_q3   <= fsync_q2;
            key_prev   <= keycode;
            state      <= state_next;
            pending    <= pending_next;
            over_cnt   <= over_cnt_next;
            frame_tick <= tick_next;
            scroll_amt <= scroll_next;
        end
    end

`ifdef GAME_SEQ_PAUSE_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            resume_state <= ST_PLAY;
        end else begin
            resume_state <= resume_next;
        end
    end
`endif

    bcd_score_counter u_score (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clear     (score_clear),
        .load      (score_load),
        .load_amt  (scroll_next),
        .freeze    (score_freeze),
        .score_bcd (score_bcd),
        .busy      (busy)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: reset, start, scroll/clamp, death, saturation, pause, async reset.
module tb_game_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  DoodleY = 10'd300;
    logic        rising = 1'b0;
    logic        frame_tick;
    logic [9:0]  scroll_amt;
    logic [2:0]  outstate;
    logic [15:0] score_bcd;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int tick_cnt = 0;
    int busy_cyc = 0;
    int trans_cnt = 0;
    int bad_scroll = 0;
    int bad_state = 0;
    int t0;
    logic [9:0] scroll_seen = 10'd0;
    logic [2:0] prev_state = 3'd0;

    game_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .DoodleY    (DoodleY),
        .rising     (rising),
        .frame_tick (frame_tick),
        .scroll_amt (scroll_amt),
        .outstate   (outstate),
        .score_bcd  (score_bcd),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (frame_tick) begin
                tick_cnt++;
                scroll_seen = scroll_amt;
            end
            if (busy) busy_cyc++;
            if (prev_state == 3'd0 && outstate == 3'd1) trans_cnt++;
            if (scroll_amt != 10'd0 && !frame_tick) bad_scroll++;
            if (outstate > 3'd4) bad_state++;
        end
        prev_state = outstate;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic scroll_frames(input logic [9:0] y);
        DoodleY = y;
        rising  = 1'b1;
        frame();
        DoodleY = 10'd300;
        rising  = 1'b0;
        frame();
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        repeat (2) @(negedge Clk);
        keycode = 8'h00;
        @(negedge Clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 400) begin
            @(negedge Clk);
            k++;
        end
        check_eq("busy_drain", busy, 1'b0);
    endtask

    task automatic die_and_return();
        DoodleY = 10'd480;
        rising  = 1'b1;
        frame();
        rising  = 1'b0;
        check_eq("dead_entry", outstate, 3'd3);
        repeat (119) frame();
        check_eq("dead_hold_119", outstate, 3'd3);
        frame();
        check_eq("dead_to_idle", outstate, 3'd0);
        DoodleY = 10'd300;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge Clk);
        check_eq("rst_outstate", outstate, 3'd0);
        check_eq("rst_score", score_bcd, 16'h0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tick", frame_tick, 1'b0);
        check_eq("rst_scroll", scroll_amt, 10'd0);
        Reset_n = 1'b1;

        // IDLE ignores frames; a held start key triggers exactly once
        repeat (3) frame();
        check_eq("idle_no_tick", tick_cnt, 0);
        check_eq("idle_state", outstate, 3'd0);
        keycode = 8'h2C;
        repeat (10) frame();
        keycode = 8'h00;
        check_eq("start_once", trans_cnt, 1);
        check_eq("play_ticks", tick_cnt, 10);
        check_eq("play_state", outstate, 3'd1);

        // Scroll by 10 from DoodleY=150
        DoodleY = 10'd150;
        rising  = 1'b1;
        frame();
        check_eq("enter_scroll", outstate, 3'd2);
        check_eq("play_frame_scroll0", scroll_seen, 10'd0);
        busy_cyc = 0;
        DoodleY = 10'd300;
        rising  = 1'b0;
        frame();
        check_eq("scroll_amt_10", scroll_seen, 10'd10);
        check_eq("back_to_play", outstate, 3'd1);
        wait_idle();
        check_eq("busy_cycles_10", busy_cyc, 10);
        check_eq("score_0010", score_bcd, 16'h0010);

        // Clamp to MAX_SCROLL, then death has priority over scrolling
        scroll_frames(10'd100);
        check_eq("scroll_clamp_16", scroll_seen, 10'd16);
        wait_idle();
        check_eq("score_0026", score_bcd, 16'h0026);
        t0 = tick_cnt + 1;
        die_and_return();
        check_eq("dead_no_ticks", tick_cnt - t0, 0);
        check_eq("score_held", score_bcd, 16'h0026);

        // New game clears score; build to 9995 then saturate
        press(8'h2C);
        check_eq("restart_state", outstate, 3'd1);
        check_eq("restart_clear", score_bcd, 16'h0000);
        repeat (624) scroll_frames(10'd100);
        scroll_frames(10'd149);
        wait_idle();
        check_eq("score_9995", score_bcd, 16'h9995);
        busy_cyc = 0;
        scroll_frames(10'd150);
        wait_idle();
        check_eq("sat_scroll_10", scroll_seen, 10'd10);
        check_eq("score_9999", score_bcd, 16'h9999);
        check_eq("sat_busy_cycles", busy_cyc, 4);
        busy_cyc = 0;
        scroll_frames(10'd100);
        check_eq("sat_no_busy", busy_cyc, 0);
        check_eq("score_stays_9999", score_bcd, 16'h9999);

        // Pause key
        press(8'h13);
`ifdef GAME_SEQ_PAUSE_EN
        check_eq("pause_enter", outstate, 3'd4);
        t0 = tick_cnt;
        repeat (2) frame();
        check_eq("pause_no_tick", tick_cnt - t0, 0);
        press(8'h13);
        check_eq("pause_resume_play", outstate, 3'd1);
        DoodleY = 10'd100;
        rising  = 1'b1;
        frame();
        rising  = 1'b0;
        DoodleY = 10'd300;
        press(8'h13);
        check_eq("pause_from_scroll", outstate, 3'd4);
        press(8'h13);
        check_eq("pause_resume_scroll", outstate, 3'd2);
        frame();
        check_eq("pending_retained", scroll_seen, 10'd16);
`else
        check_eq("pause_ignored", outstate, 3'd1);
        t0 = tick_cnt;
        repeat (2) frame();
        check_eq("pause_ignored_ticks", tick_cnt - t0, 2);
`endif

        // Asynchronous reset while SCROLL and busy
        die_and_return();
        press(8'h2C);
        check_eq("third_game_clear", score_bcd, 16'h0000);
        DoodleY = 10'd100;
        rising  = 1'b1;
        repeat (3) frame();
        check_eq("pre_rst_scroll", outstate, 3'd2);
        check_eq("pre_rst_busy", busy, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("arst_outstate", outstate, 3'd0);
        check_eq("arst_score", score_bcd, 16'h0000);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_tick", frame_tick, 1'b0);
        check_eq("arst_scroll", scroll_amt, 10'd0);
        rising = 1'b0;

        check_eq("scroll_outside_tick", bad_scroll, 0);
        check_eq("illegal_state", bad_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
